// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// ---------------------------------------------------------------------------
// AHB-Lite responder in front of one single-port, word-organised synchronous
// SRAM macro. The SRAM has a one-cycle registered read.
//
// Read handling: a legal read is presented to the SRAM combinationally in its
// address phase, so the data returns in the data phase with no wait state.
//
// Write handling: a write is held until its data phase, because that is when
// HWDATA arrives. A read accepted during a write data phase would collide
// with that write on the single SRAM port. It is latched and replayed one
// cycle later, so the bus sees exactly one wait state. Because the write
// commits first, a read of the same word returns the new data.
//
// Error handling: a transfer that is not a word-sized, word-aligned access is
// answered with the two-cycle AHB ERROR response and never reaches the SRAM.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   HSEL..HREADY    AHB-Lite slave inputs (HBURST ignored)
//   HRDATA          read data (zero outside a read data phase)
//   HREADYOUT       this slave's ready
//   HRESP           0 = OKAY, 1 = ERROR
//   MEM_enable      SRAM enable
//   MEM_write       SRAM write strobe
//   MEM_address     SRAM word address
//   MEM_in          SRAM write data
//   MEM_out         SRAM read data (one cycle after an enabled read)
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  MEM_enable,
    output logic                  MEM_write,
    output logic [ADDR_WIDTH-1:0] MEM_address,
    output logic [DATA_WIDTH-1:0] MEM_in,
    input  logic [DATA_WIDTH-1:0] MEM_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RD_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;

    logic                  accept;
    logic                  illegal;
    logic                  port_free;
    logic [ADDR_WIDTH-1:0] haddr_word;

    // Decoder-owned upper address bits, burst type and the SEQ/NONSEQ
    // distinction carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    assign accept     = HSEL & HTRANS[1] & HREADY & ~rst;
    assign illegal    = (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00);
    assign haddr_word = HADDR[ADDR_WIDTH+1:2];

    // The SRAM port is free for a fresh read in every state that is not
    // itself using it (WR, RD_WAIT) or stalling the bus (ERR1).
    assign port_free  = (state == S_IDLE) | (state == S_RD) | (state == S_ERR2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            waddr <= '0;
            raddr <= '0;
        end else begin
            case (state)
                S_RD_WAIT: state <= S_RD;
                S_ERR1:    state <= S_ERR2;
                default: begin
                    // IDLE, RD, WR and ERR2 all complete their data phase
                    // this cycle and may accept the next address phase.
                    if (!accept) begin
                        state <= S_IDLE;
                    end else if (illegal) begin
                        state <= S_ERR1;
                    end else if (HWRITE) begin
                        waddr <= haddr_word;
                        state <= S_WR;
                    end else if (state == S_WR) begin
                        // Port busy with the pending write: replay next cycle.
                        raddr <= haddr_word;
                        state <= S_RD_WAIT;
                    end else begin
                        state <= S_RD;
                    end
                end
            endcase
        end
    end

    always_comb begin
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        HRDATA      = '0;
        MEM_enable  = 1'b0;
        MEM_write   = 1'b0;
        MEM_address = '0;
        MEM_in      = '0;
        // Everything is held at its idle value while reset is asserted, so
        // a write pending in WR never strobes the SRAM in the reset cycle.
        if (!rst) begin
            case (state)
                S_RD: HRDATA = MEM_out;
                S_WR: begin
                    MEM_enable  = 1'b1;
                    MEM_write   = 1'b1;
                    MEM_address = waddr;
                    MEM_in      = HWDATA;
                end
                S_RD_WAIT: begin
                    HREADYOUT   = 1'b0;
                    MEM_enable  = 1'b1;
                    MEM_address = raddr;
                end
                S_ERR1: begin
                    HREADYOUT = 1'b0;
                    HRESP     = 1'b1;
                end
                S_ERR2: HRESP = 1'b1;
                default: ;
            endcase
            // Zero-wait read: issue in the address phase so the registered
            // SRAM output lines up with the data phase.
            if (port_free && accept && !illegal && !HWRITE) begin
                MEM_enable  = 1'b1;
                MEM_address = haddr_word;
            end
        end
    end

endmodule
